fwrisc_wb_arbiter_2x1: RTL and testbench

- Downstream neighbour of the RV32I Wishbone core wrapper.
- Merges the core's instruction (wbi_) and data (wbd_) Wishbone initiator ports onto one shared Wishbone initiator bus (wbm_) that feeds a single memory/peripheral target.
- Registered round-robin arbitration; grant is held for a whole Wishbone cycle (cyc high).

---
 rtl/fwrisc_wb_arb_pkg.sv | 6 +
 rtl/fwrisc_wb_arb_timeout.sv | 17 +
 rtl/fwrisc_wb_arbiter_2x1.sv | 91 +++++++++
 tb/tb_fwrisc_wb_arbiter_2x1.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fwrisc_wb_arb_pkg.sv
// fwrisc_wb_arb_pkg: shared state encoding and port ids for the 2x1 Wishbone arbiter
package fwrisc_wb_arb_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_GNT_I, ARB_GNT_D} arb_state_e;
  localparam logic ARB_PORT_I = 1'b0;
  localparam logic ARB_PORT_D = 1'b1;
endpackage

// File: rtl/fwrisc_wb_arb_timeout.sv
// fwrisc_wb_arb_timeout: stall watchdog that flags the cycle in which the owner has waited TIMEOUT_CYCLES beats
module fwrisc_wb_arb_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic stall,
  input  logic rsp,
  output logic timeout
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = (clr || rsp) ? '0 : stall ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clock) cnt_q <= !reset ? '0 : cnt_d;
  assign timeout = stall && (cnt_q == W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/fwrisc_wb_arbiter_2x1.sv
// fwrisc_wb_arbiter_2x1: round-robin merge of instruction/data Wishbone initiators, optional watchdog via FWRISC_WB_ARB_TIMEOUT_EN
module fwrisc_wb_arbiter_2x1
  import fwrisc_wb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   wbi_adr,
  input  logic [DATA_WIDTH-1:0]   wbi_dat_w,
  input  logic [DATA_WIDTH/8-1:0] wbi_sel,
  input  logic                    wbi_we,
  input  logic                    wbi_cyc,
  input  logic                    wbi_stb,
  output logic [DATA_WIDTH-1:0]   wbi_dat_r,
  output logic                    wbi_ack,
  output logic                    wbi_err,
  input  logic [ADDR_WIDTH-1:0]   wbd_adr,
  input  logic [DATA_WIDTH-1:0]   wbd_dat_w,
  input  logic [DATA_WIDTH/8-1:0] wbd_sel,
  input  logic                    wbd_we,
  input  logic                    wbd_cyc,
  input  logic                    wbd_stb,
  output logic [DATA_WIDTH-1:0]   wbd_dat_r,
  output logic                    wbd_ack,
  output logic                    wbd_err,
  output logic [ADDR_WIDTH-1:0]   wbm_adr,
  output logic [DATA_WIDTH-1:0]   wbm_dat_w,
  output logic [DATA_WIDTH/8-1:0] wbm_sel,
  output logic                    wbm_we,
  output logic                    wbm_cyc,
  output logic                    wbm_stb,
  input  logic [DATA_WIDTH-1:0]   wbm_dat_r,
  input  logic                    wbm_ack,
  input  logic                    wbm_err
);
  arb_state_e state_q, state_d;
  logic last_gnt_q, last_gnt_d;
  logic gnt_i, gnt_d, own_cyc, timeout;
  assign gnt_i = state_q == ARB_GNT_I;
  assign gnt_d = state_q == ARB_GNT_D;
  assign own_cyc = gnt_i ? wbi_cyc : gnt_d ? wbd_cyc : 1'b0;
`ifdef FWRISC_WB_ARB_TIMEOUT_EN
  fwrisc_wb_arb_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clr     (state_q == ARB_IDLE),
    .stall   (wbm_cyc && wbm_stb && !(wbm_ack || wbm_err)),
    .rsp     (wbm_ack || wbm_err),
    .timeout (timeout)
  );
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = |TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    last_gnt_d = last_gnt_q;
    if (state_q == ARB_IDLE)
      state_d = (wbi_cyc && wbd_cyc) ? ((last_gnt_q == ARB_PORT_I) ? ARB_GNT_D : ARB_GNT_I) :
                wbi_cyc ? ARB_GNT_I : wbd_cyc ? ARB_GNT_D : ARB_IDLE;
    else if (!own_cyc || timeout) begin
      state_d = ARB_IDLE;
      last_gnt_d = gnt_d ? ARB_PORT_D : ARB_PORT_I;
    end
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ARB_IDLE;
      last_gnt_q <= ARB_PORT_I;
    end else begin
      state_q <= state_d;
      last_gnt_q <= last_gnt_d;
    end
  end
  assign wbm_adr   = gnt_i ? wbi_adr   : gnt_d ? wbd_adr   : '0;
  assign wbm_dat_w = gnt_i ? wbi_dat_w : gnt_d ? wbd_dat_w : '0;
  assign wbm_sel   = gnt_i ? wbi_sel   : gnt_d ? wbd_sel   : '0;
  assign wbm_we    = gnt_i ? wbi_we    : gnt_d ? wbd_we    : 1'b0;
  assign wbm_cyc   = own_cyc;
  assign wbm_stb   = gnt_i ? wbi_stb   : gnt_d ? wbd_stb   : 1'b0;
  assign wbi_ack   = gnt_i && wbm_ack;
  assign wbd_ack   = gnt_d && wbm_ack;
  assign wbi_err   = gnt_i && (wbm_err || timeout);
  assign wbd_err   = gnt_d && (wbm_err || timeout);
  assign wbi_dat_r = wbm_dat_r;
  assign wbd_dat_r = wbm_dat_r;
endmodule

// File: tb/tb_fwrisc_wb_arbiter_2x1.sv
// tb_fwrisc_wb_arbiter_2x1: directed self-checking bench for the 2x1 Wishbone arbiter (timeout case under FWRISC_WB_ARB_TIMEOUT_EN)
module tb_fwrisc_wb_arbiter_2x1;
  logic clock = 0;
  logic reset = 0;
  logic [31:0] wbi_adr = 0, wbi_dat_w = 0, wbd_adr = 0, wbd_dat_w = 0;
  logic [3:0]  wbi_sel = 0, wbd_sel = 0;
  logic wbi_we = 0, wbi_cyc = 0, wbi_stb = 0, wbd_we = 0, wbd_cyc = 0, wbd_stb = 0;
  logic [31:0] wbi_dat_r, wbd_dat_r, wbm_adr, wbm_dat_w;
  logic [3:0]  wbm_sel;
  logic wbi_ack, wbi_err, wbd_ack, wbd_err, wbm_we, wbm_cyc, wbm_stb;
  logic [31:0] wbm_dat_r = 0;
  logic wbm_ack = 0, wbm_err = 0;
  int errors = 0, checks = 0;
  always #5 clock = ~clock;
  fwrisc_wb_arbiter_2x1 #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clock(clock), .reset(reset),
    .wbi_adr(wbi_adr), .wbi_dat_w(wbi_dat_w), .wbi_sel(wbi_sel), .wbi_we(wbi_we),
    .wbi_cyc(wbi_cyc), .wbi_stb(wbi_stb), .wbi_dat_r(wbi_dat_r), .wbi_ack(wbi_ack), .wbi_err(wbi_err),
    .wbd_adr(wbd_adr), .wbd_dat_w(wbd_dat_w), .wbd_sel(wbd_sel), .wbd_we(wbd_we),
    .wbd_cyc(wbd_cyc), .wbd_stb(wbd_stb), .wbd_dat_r(wbd_dat_r), .wbd_ack(wbd_ack), .wbd_err(wbd_err),
    .wbm_adr(wbm_adr), .wbm_dat_w(wbm_dat_w), .wbm_sel(wbm_sel), .wbm_we(wbm_we),
    .wbm_cyc(wbm_cyc), .wbm_stb(wbm_stb), .wbm_dat_r(wbm_dat_r), .wbm_ack(wbm_ack), .wbm_err(wbm_err)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic edge_drive;
    @(posedge clock);
    #1;
  endtask
  task automatic sample;
    @(negedge clock);
  endtask
  initial begin
    edge_drive();
    edge_drive();
    sample();
    chk("rst_cyc", wbm_cyc, 0);
    chk("rst_stb", wbm_stb, 0);
    chk("rst_adr", wbm_adr, 0);
    chk("rst_acks", {wbi_ack, wbd_ack, wbi_err, wbd_err}, 0);
    edge_drive();
    reset = 1;
    for (int i = 0; i < 5; i++) begin
      edge_drive();
      sample();
      chk("idle_cyc", wbm_cyc, 0);
      chk("idle_acks", {wbi_ack, wbd_ack}, 0);
    end
    edge_drive();
    wbi_cyc = 1; wbi_stb = 1; wbi_adr = 32'h100;
    sample();
    chk("i_c0_cyc", wbm_cyc, 0);
    edge_drive();
    sample();
    chk("i_c1_cyc", wbm_cyc, 1);
    chk("i_c1_adr", wbm_adr, 32'h100);
    edge_drive();
    sample();
    chk("i_c2_dack", wbd_ack, 0);
    edge_drive();
    wbm_ack = 1; wbm_dat_r = 32'hDEADBEEF;
    sample();
    chk("i_c3_ack", wbi_ack, 1);
    chk("i_c3_dat", wbi_dat_r, 32'hDEADBEEF);
    chk("i_c3_dack", wbd_ack, 0);
    edge_drive();
    wbm_ack = 0; wbi_cyc = 0; wbi_stb = 0;
    sample();
    chk("i_drop_cyc", wbm_cyc, 0);
    edge_drive();
    reset = 0;
    edge_drive();
    reset = 1;
    wbi_cyc = 1; wbi_stb = 1; wbi_adr = 32'h300; wbi_we = 0; wbi_sel = 4'h3;
    wbd_cyc = 1; wbd_stb = 1; wbd_adr = 32'h2000; wbd_we = 1; wbd_sel = 4'hF; wbd_dat_w = 32'h12345678;
    sample();
    chk("cont_c0_cyc", wbm_cyc, 0);
    edge_drive();
    sample();
    chk("cont_d_cyc", wbm_cyc, 1);
    chk("cont_d_adr", wbm_adr, 32'h2000);
    chk("cont_d_we", wbm_we, 1);
    chk("cont_d_sel", wbm_sel, 4'hF);
    chk("cont_d_datw", wbm_dat_w, 32'h12345678);
    edge_drive();
    wbm_ack = 1; wbm_err = 1;
    sample();
    chk("cont_d_ackerr", {wbd_ack, wbd_err}, 2'b11);
    chk("cont_i_ackerr", {wbi_ack, wbi_err}, 2'b00);
    edge_drive();
    wbm_ack = 0; wbm_err = 0; wbd_cyc = 0; wbd_stb = 0; wbd_we = 0;
    sample();
    chk("cont_drop_cyc", wbm_cyc, 0);
    edge_drive();
    sample();
    chk("cont_bubble_cyc", wbm_cyc, 0);
    edge_drive();
    sample();
    chk("cont_i_cyc", wbm_cyc, 1);
    chk("cont_i_adr", wbm_adr, 32'h300);
    chk("cont_i_sel", wbm_sel, 4'h3);
    edge_drive();
    wbm_ack = 1;
    edge_drive();
    wbm_ack = 0; wbi_cyc = 0; wbi_stb = 0;
    edge_drive();
    edge_drive();
    wbd_cyc = 1; wbd_stb = 1; wbd_adr = 32'h40;
    wbi_cyc = 1; wbi_stb = 1; wbi_adr = 32'h500;
    edge_drive();
    for (int b = 0; b < 3; b++) begin
      wbd_adr = 32'h40 + 32'(4 * b);
      wbm_ack = 1;
      sample();
      chk("burst_adr", wbm_adr, 32'h40 + 32'(4 * b));
      chk("burst_dack", wbd_ack, 1);
      chk("burst_iack", wbi_ack, 0);
      edge_drive();
    end
    wbm_ack = 0; wbd_cyc = 0; wbd_stb = 0;
    sample();
    chk("burst_drop_cyc", wbm_cyc, 0);
    edge_drive();
    sample();
    chk("burst_bubble_cyc", wbm_cyc, 0);
    edge_drive();
    sample();
    chk("burst_i_cyc", wbm_cyc, 1);
    chk("burst_i_adr", wbm_adr, 32'h500);
    edge_drive();
    reset = 0;
    sample();
    chk("mid_rst_hold", wbm_cyc, 1);
    edge_drive();
    sample();
    chk("mid_rst_cyc", wbm_cyc, 0);
    chk("mid_rst_adr", wbm_adr, 0);
    reset = 1;
    wbd_cyc = 1; wbd_stb = 1; wbd_adr = 32'h2004;
    edge_drive();
    sample();
    chk("post_rst_d_adr", wbm_adr, 32'h2004);
    edge_drive();
    wbd_cyc = 0; wbd_stb = 0; wbi_cyc = 0; wbi_stb = 0;
`ifdef FWRISC_WB_ARB_TIMEOUT_EN
    reset = 0;
    edge_drive();
    reset = 1;
    wbi_cyc = 1; wbi_stb = 1; wbi_adr = 32'h700;
    edge_drive();
    wbd_cyc = 1; wbd_stb = 1; wbd_adr = 32'h800;
    for (int s = 1; s <= 3; s++) begin
      sample();
      chk("to_stall_err", wbi_err, 0);
      edge_drive();
    end
    sample();
    chk("to_err", wbi_err, 1);
    chk("to_derr", wbd_err, 0);
    edge_drive();
    sample();
    chk("to_release_cyc", wbm_cyc, 0);
    chk("to_release_err", wbi_err, 0);
    edge_drive();
    sample();
    chk("to_d_adr", wbm_adr, 32'h800);
    edge_drive();
    wbd_cyc = 0; wbd_stb = 0; wbi_cyc = 0; wbi_stb = 0;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
